// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor with a segmented carry chain.
//
// The WIDTH-bit add is split into STAGES segments of WIDTH/STAGES bits. Stage k adds
// segment k using the carry registered by stage k-1. The last stage register is the
// output register, so an accepted operand set appears on result/flags exactly STAGES
// cycles later unless the pipeline stalls.
//
// Parameters:
//   WIDTH   operand/result width (8..64), must be divisible by STAGES
//   STAGES  pipeline depth and carry-chain segment count (1..8)
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand set on input_1/input_2/op/carry_in is valid
//   in_ready   operand set is accepted this cycle (equals the advance condition)
//   input_1    operand A
//   input_2    operand B
//   op         00 ADD, 01 SUB, 10 ADDC, 11 SUBB
//   carry_in   carry/borrow input for ADDC/SUBB
//   out_valid  result and flags are valid
//   out_ready  downstream accepts the result this cycle
//   result     sum or difference modulo 2^WIDTH
//   flags      {N, Z, C, V}
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [1:0]       op,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned SEG = WIDTH / STAGES;

    // Per-stage pipeline registers. Each stage carries the full operands forward;
    // bits below the current segment are simply never read again.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic [3:0]       flags_q;

    // Stage inputs and next-state values.
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];
    logic [WIDTH-1:0] sum_d  [STAGES];
    logic             c_d    [STAGES];
    logic [3:0]       flags_d;
    logic [SEG:0]     seg;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Whole pipeline moves in lockstep; bubbles are never squeezed out.
    assign advance   = !v_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign result    = sum_q[STAGES-1];
    assign flags     = flags_q;

    // Subtraction is an add of ~B. Carry-in: ADD 0, SUB 1, ADDC carry_in, SUBB ~carry_in.
    assign b_eff = op[0] ? ~input_2 : input_2;
    assign c_eff = op[1] ? (carry_in ^ op[0]) : op[0];

    always_comb begin
        a_in[0]   = input_1;
        b_in[0]   = b_eff;
        sum_in[0] = '0;
        c_in[0]   = c_eff;
        v_in[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            sum_in[k] = sum_q[k-1];
            c_in[k]   = c_q[k-1];
            v_in[k]   = v_q[k-1];
        end

        seg = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_in[k]};
            sum_d[k]               = sum_in[k];
            sum_d[k][k*SEG +: SEG] = seg[SEG-1:0];
            c_d[k]                 = seg[SEG];
        end

        // Flags are formed as the final segment completes and registered with the result.
        flags_d[3] = sum_d[STAGES-1][WIDTH-1];
        flags_d[2] = (sum_d[STAGES-1] == '0);
        flags_d[1] = c_d[STAGES-1];
        flags_d[0] = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
                  && (sum_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
            end
            flags_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= c_d[k];
                v_q[k]   <= v_in[k];
            end
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=32, STAGES=4).
// Stimulus pushes hand-computed expectations at acceptance; a monitor pops and
// compares on every output handshake, including the latency where no stall occurs.
module tb_pipelined_add_sub;

    localparam int W = 32;
    localparam int S = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDC = 2'b10;
    localparam logic [1:0] OP_SUBB = 2'b11;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] input_1   = '0;
    logic [W-1:0] input_2   = '0;
    logic [1:0]   op        = 2'b00;
    logic         carry_in  = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [3:0]   flags;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         lat;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] nx_res = '0;
    logic [3:0]   nx_flg = '0;
    logic         lat_en = 1'b1;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_out    = 0;
    int           cyc      = 0;

    pipelined_add_sub #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_1   (input_1),
        .input_2   (input_2),
        .op        (op),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                check("output has scoreboard entry", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("flags", 64'(flags), 64'(e.flg));
                    if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(S));
                end
            end
            if (in_valid && in_ready) begin
                e.res = nx_res;
                e.flg = nx_flg;
                e.lat = lat_en;
                e.cyc = cyc;
                sb_q.push_back(e);
            end
        end
    end

    // Present one operand set and hold it until accepted (bounded).
    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] r, input logic [3:0] f);
        int t = 0;
        op       = o;
        input_1  = a;
        input_2  = b;
        carry_in = ci;
        nx_res   = r;
        nx_flg   = f;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 50);
        if (!in_ready) check("in_ready within bound", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        idle(2);
        check("scoreboard drained", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        int outs_before;

        // Reset state is visible before any clock edge.
        reset_n = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset result", 64'(result), 64'(0));
        check("reset flags", 64'(flags), 64'(0));
        idle(2);
        reset_n = 1'b1;

        // Directed vectors; flags are {N,Z,C,V}.
        send(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110);
        idle(1);
        send(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001);
        idle(2);
        send(OP_SUB,  32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 4'b1000);
        send(OP_ADDC, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 4'b0000);
        send(OP_SUBB, 32'd10,        32'd3,         1'b1, 32'h0000_0006, 4'b0010);
        send(OP_SUB,  32'd7,         32'd7,         1'b0, 32'h0000_0000, 4'b0110);
        send(OP_ADD,  32'd1,         32'd1,         1'b1, 32'h0000_0002, 4'b0000);
        send(OP_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        send(OP_SUBB, 32'd0,         32'd0,         1'b0, 32'h0000_0000, 4'b0110);
        send(OP_ADDC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110);
        send(OP_ADD,  32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 4'b0000);
        send(OP_SUB,  32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 4'b0010);
        drain();

        // Backpressure: 8 back-to-back ADDs, stall 6 cycles from first out_valid.
        lat_en = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    send(OP_ADD, W'(i), W'(i), 1'b0, W'(2 * i), 4'b0000);
                end
            end
            begin
                int t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!out_valid && t < 50);
                check("first out_valid in backpressure", 64'(out_valid), 64'(1));
                out_ready = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    check("stalled in_ready", 64'(in_ready), 64'(0));
                    check("stalled out_valid", 64'(out_valid), 64'(1));
                    check("stalled result", 64'(result), 64'(2));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        lat_en = 1'b1;

        // Reset mid-operation: oldest op at the output, three more in flight.
        for (int i = 0; i < 4; i++) begin
            send(OP_ADD, W'(100 + i), 32'd1, 1'b0, W'(101 + i), 4'b0000);
        end
        #1;
        check("out_valid before mid reset", 64'(out_valid), 64'(1));
        reset_n = 1'b0;
        #1;
        check("mid reset out_valid", 64'(out_valid), 64'(0));
        check("mid reset result", 64'(result), 64'(0));
        check("mid reset flags", 64'(flags), 64'(0));
        check("mid reset in_ready", 64'(in_ready), 64'(1));
        sb_q.delete();
        #1;
        reset_n = 1'b1;
        outs_before = n_out;
        send(OP_ADD, 32'd1, 32'd1, 1'b0, 32'd2, 4'b0000);
        drain();
        idle(10);
        check("outputs after mid reset", 64'(n_out - outs_before), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
